// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared types and constants for the elastic pipeline stage
//
// Package pipe_pkg: occupancy state encoding, default widths and the
// hard-wired zero register index used by the hazard lookup.
// Optional feature macro used by the stage: PIPE_STAGE_SKID_PERF_EN.

package pipe_pkg;

   // Occupancy of the stage: EMPTY, ONE (main only), TWO (main + skid).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   // Register index that never creates a hazard (x0 is hard-wired).
   localparam int ZERO_REG = 0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - one valid/ready link between pipeline stages
//
// Signals:
//   valid - entry present on the link
//   ready - receiver accepts the entry this cycle
//   data  - DATA_W payload
//   rd    - destination register index
//   wen   - entry writes the register file
// Modports:
//   master - drives valid/data/rd/wen, samples ready
//   slave  - samples valid/data/rd/wen, drives ready

interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W
);

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [REG_W-1:0]  rd;
   logic              wen;

   modport master (
      output valid,
      output data,
      output rd,
      output wen,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  rd,
      input  wen,
      output ready
   );

endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// rtl/pipe_stage_skid_entry_reg.sv - one held pipeline entry (payload, rd, wen)
//
// Module pipe_entry_reg, used for both the main and the skid slot.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   load              - capture d_* this cycle
//   clear             - squash to RESET_DATA / rd 0 / wen 0 (wins over load)
//   d_data/d_rd/d_wen - next entry contents
//   q_data/q_rd/q_wen - held entry contents

module pipe_entry_reg #(
   parameter int                DATA_W     = 32,
   parameter int                REG_W      = 5,
   parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [REG_W-1:0]  d_rd,
   input  logic              d_wen,
   output logic [DATA_W-1:0] q_data,
   output logic [REG_W-1:0]  q_rd,
   output logic              q_wen
);

   logic [DATA_W-1:0] data_q, data_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic              wen_q, wen_d;

   always_comb begin
      data_d = data_q;
      rd_d   = rd_q;
      wen_d  = wen_q;
      if (clear) begin
         data_d = RESET_DATA;
         rd_d   = '0;
         wen_d  = 1'b0;
      end else if (load) begin
         data_d = d_data;
         rd_d   = d_rd;
         wen_d  = d_wen;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= RESET_DATA;
         rd_q   <= '0;
         wen_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         rd_q   <= rd_d;
         wen_q  <= wen_d;
      end
   end

   assign q_data = data_q;
   assign q_rd   = rd_q;
   assign q_wen  = wen_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage with 2-entry skid buffer
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   flush     - synchronous squash of all held entries
//   up        - upstream link (slave): valid/data/rd/wen in, ready out
//   dn        - downstream link (master): oldest entry out, ready in
//   query_rd  - hazard-unit source register
//   rd_match  - a held valid entry writes query_rd (never for register 0)
//   stall_cnt - cycles with dn.valid & ~dn.ready, saturating   (PIPE_STAGE_SKID_PERF_EN)
//   flush_cnt - flushes that squashed at least one entry, saturating (PIPE_STAGE_SKID_PERF_EN)
// Optional feature macro: PIPE_STAGE_SKID_PERF_EN.

module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = DEF_DATA_W,
   parameter int                REG_W      = DEF_REG_W,
   parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_skid_if.slave  up,
   pipe_stage_skid_if.master dn,
   input  logic [REG_W-1:0]  query_rd,
   output logic              rd_match
`ifdef PIPE_STAGE_SKID_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   state_e state_q, state_d;

   // in_ready and out_valid each come from their own flop so that neither
   // handshake output has a combinational path from the other side.
   logic in_ready_q;
   logic out_valid_q;

   logic in_fire;
   logic out_fire;

   logic main_load;
   logic main_from_skid;
   logic skid_load;

   logic [DATA_W-1:0] main_data, skid_data, main_d_data;
   logic [REG_W-1:0]  main_rd, skid_rd, main_d_rd;
   logic              main_wen, skid_wen, main_d_wen;

   assign in_fire  = up.valid & in_ready_q;
   assign out_fire = out_valid_q & dn.ready;

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_load = 1'b1;
               state_d   = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_load = 1'b1;
            end else if (in_fire) begin
               skid_load = 1'b1;
               state_d   = ST_TWO;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush overrides every handshake event; the entry registers see the
      // same flush as their clear, which wins over any load.
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != ST_TWO);
         out_valid_q <= (state_d != ST_EMPTY);
      end
   end

   // Main refills from the skid slot when draining TWO, else from upstream.
   assign main_d_data = main_from_skid ? skid_data : up.data;
   assign main_d_rd   = main_from_skid ? skid_rd   : up.rd;
   assign main_d_wen  = main_from_skid ? skid_wen  : up.wen;

   pipe_entry_reg #(
      .DATA_W    (DATA_W),
      .REG_W     (REG_W),
      .RESET_DATA(RESET_DATA)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (flush),
      .d_data(main_d_data),
      .d_rd  (main_d_rd),
      .d_wen (main_d_wen),
      .q_data(main_data),
      .q_rd  (main_rd),
      .q_wen (main_wen)
   );

   pipe_entry_reg #(
      .DATA_W    (DATA_W),
      .REG_W     (REG_W),
      .RESET_DATA(RESET_DATA)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (flush),
      .d_data(up.data),
      .d_rd  (up.rd),
      .d_wen (up.wen),
      .q_data(skid_data),
      .q_rd  (skid_rd),
      .q_wen (skid_wen)
   );

   assign up.ready = in_ready_q;
   assign dn.valid = out_valid_q;
   assign dn.data  = main_data;
   assign dn.rd    = main_rd;
   assign dn.wen   = main_wen;

   // Stale contents of an emptied slot must not match, so each slot is
   // qualified by the occupancy state rather than by its own wen alone.
   always_comb begin
      rd_match = 1'b0;
      if (query_rd != REG_W'(ZERO_REG)) begin
         if ((state_q != ST_EMPTY) && main_wen && (main_rd == query_rd)) begin
            rd_match = 1'b1;
         end
         if ((state_q == ST_TWO) && skid_wen && (skid_rd == query_rd)) begin
            rd_match = 1'b1;
         end
      end
   end

`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (out_valid_q && !dn.ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid

module tb_pipe_stage_skid;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [4:0] query_rd;
   logic       rd_match;
`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [31:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_stage_skid_if #(.DATA_W(32), .REG_W(5)) up_if ();
   pipe_stage_skid_if #(.DATA_W(32), .REG_W(5)) dn_if ();

   pipe_stage_skid #(
      .DATA_W    (32),
      .REG_W     (5),
      .RESET_DATA(32'h0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up       (up_if.slave),
      .dn       (dn_if.master),
      .query_rd (query_rd),
      .rd_match (rd_match)
`ifdef PIPE_STAGE_SKID_PERF_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] id;
      logic [4:0]  ird;
      logic        iwen;
      logic        ordy;
      logic [4:0]  qrd;
      logic        ov;
      logic        ir;
      logic [31:0] od;
      logic [4:0]  ord;
      logic        owen;
      logic        rm;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wen;
   } ent_t;

   vec_t vecs[$];
   ent_t model_q[$];

   function automatic vec_t mk(logic fl, logic iv, logic [31:0] id, logic [4:0] ird,
                               logic iwen, logic ordy, logic [4:0] qrd, logic ov,
                               logic ir, logic [31:0] od, logic [4:0] ord,
                               logic owen, logic rm);
      vec_t v;
      v.fl = fl; v.iv = iv; v.id = id; v.ird = ird; v.iwen = iwen; v.ordy = ordy;
      v.qrd = qrd; v.ov = ov; v.ir = ir; v.od = od; v.ord = ord; v.owen = owen;
      v.rm = rm;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one cycle of inputs, clock it, and settle just after the edge.
   task automatic drive(input logic fl, input logic iv, input logic [31:0] id,
                        input logic [4:0] ird, input logic iwen, input logic ordy,
                        input logic [4:0] qrd);
      flush       = fl;
      up_if.valid = iv;
      up_if.data  = id;
      up_if.rd    = ird;
      up_if.wen   = iwen;
      dn_if.ready = ordy;
      query_rd    = qrd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      flush       = 1'b0;
      up_if.valid = 1'b0;
      up_if.data  = '0;
      up_if.rd    = '0;
      up_if.wen   = 1'b0;
      dn_if.ready = 1'b0;
      query_rd    = '0;

      // Streaming at full rate
      vecs.push_back(mk(0,1,32'h11,5'd1,1,1,5'd0, 1,1,32'h11,5'd1,1,0));
      vecs.push_back(mk(0,1,32'h22,5'd2,1,1,5'd0, 1,1,32'h22,5'd2,1,0));
      vecs.push_back(mk(0,1,32'h33,5'd3,1,1,5'd0, 1,1,32'h33,5'd3,1,0));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd0, 0,1,32'h0, 5'd0,0,0));
      // Stall into skid, then drain in order; in_valid ignored while not ready
      vecs.push_back(mk(0,1,32'hA1,5'd3,1,0,5'd4, 1,1,32'hA1,5'd3,1,0));
      vecs.push_back(mk(0,1,32'hA2,5'd4,1,0,5'd4, 1,0,32'hA1,5'd3,1,1));
      vecs.push_back(mk(0,1,32'hBB,5'd5,1,1,5'd3, 1,1,32'hA2,5'd4,1,0));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd4, 0,1,32'h0, 5'd0,0,0));
      // Flush from TWO with an offered entry
      vecs.push_back(mk(0,1,32'h31,5'd3,1,0,5'd3, 1,1,32'h31,5'd3,1,1));
      vecs.push_back(mk(0,1,32'h41,5'd4,1,0,5'd4, 1,0,32'h31,5'd3,1,1));
      vecs.push_back(mk(1,1,32'h55,5'd5,1,0,5'd3, 0,1,32'h0, 5'd0,0,0));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd5, 0,1,32'h0, 5'd0,0,0));
      // Flush from ONE while both in_fire and out_fire
      vecs.push_back(mk(0,1,32'h66,5'd6,1,0,5'd6, 1,1,32'h66,5'd6,1,1));
      vecs.push_back(mk(1,1,32'h77,5'd7,1,1,5'd7, 0,1,32'h0, 5'd0,0,0));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd7, 0,1,32'h0, 5'd0,0,0));
      // Hazard lookup boundaries
      vecs.push_back(mk(0,1,32'h70,5'd7,1,0,5'd7, 1,1,32'h70,5'd7,1,1));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd7, 0,1,32'h0, 5'd0,0,0));
      vecs.push_back(mk(0,1,32'h80,5'd0,1,0,5'd0, 1,1,32'h80,5'd0,1,0));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd0, 0,1,32'h0, 5'd0,0,0));
      vecs.push_back(mk(0,1,32'h90,5'd7,0,0,5'd7, 1,1,32'h90,5'd7,0,0));
      vecs.push_back(mk(0,0,32'h0, 5'd0,0,1,5'd7, 0,1,32'h0, 5'd0,0,0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
      chk("rst_in_ready",  32'(up_if.ready), 32'd1);
      chk("rst_out_data",  dn_if.data, 32'h0);
      chk("rst_out_rd",    32'(dn_if.rd), 32'd0);
      chk("rst_out_wen",   32'(dn_if.wen), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_rd_match",  32'(rd_match), 32'd0);

`ifdef PIPE_STAGE_SKID_PERF_EN
      chk("perf_stall_reset", stall_cnt, 32'd0);
      chk("perf_flush_reset", 32'(flush_cnt), 32'd0);
      drive(0,1,32'hE1,5'd1,1,0,5'd0);
      chk("perf_stall_load", stall_cnt, 32'd0);
      for (int i = 0; i < 5; i++) drive(0,0,32'h0,5'd0,0,0,5'd0);
      chk("perf_stall_5", stall_cnt, 32'd5);
      drive(1,0,32'h0,5'd0,0,1,5'd0);
      chk("perf_flush_nonempty", 32'(flush_cnt), 32'd1);
      chk("perf_stall_after_flush", stall_cnt, 32'd5);
      drive(1,0,32'h0,5'd0,0,1,5'd0);
      chk("perf_flush_empty", 32'(flush_cnt), 32'd1);
`endif

      foreach (vecs[i]) begin
         drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ird, vecs[i].iwen,
               vecs[i].ordy, vecs[i].qrd);
         chk($sformatf("vec%0d_out_valid", i), 32'(dn_if.valid), 32'(vecs[i].ov));
         chk($sformatf("vec%0d_in_ready", i),  32'(up_if.ready), 32'(vecs[i].ir));
         chk($sformatf("vec%0d_rd_match", i),  32'(rd_match),    32'(vecs[i].rm));
         if (vecs[i].ov) begin
            chk($sformatf("vec%0d_out_data", i), dn_if.data,       vecs[i].od);
            chk($sformatf("vec%0d_out_rd", i),   32'(dn_if.rd),    32'(vecs[i].ord));
            chk($sformatf("vec%0d_out_wen", i),  32'(dn_if.wen),   32'(vecs[i].owen));
         end
      end

      // Asynchronous reset while holding two entries
      drive(0,1,32'hC1,5'd1,1,0,5'd2);
      drive(0,1,32'hC2,5'd2,1,0,5'd2);
      chk("areset_pre_in_ready", 32'(up_if.ready), 32'd0);
      chk("areset_pre_rd_match", 32'(rd_match), 32'd1);
      up_if.valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("areset_out_valid", 32'(dn_if.valid), 32'd0);
      chk("areset_in_ready",  32'(up_if.ready), 32'd1);
      chk("areset_rd_match",  32'(rd_match), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomised traffic against a queue model of capacity two
      for (int n = 0; n < 2000; n++) begin
         logic        fl, iv, wen, ordy;
         logic [31:0] d;
         logic [4:0]  rd, q;
         logic        can_in, can_out, exp_rm;
         ent_t        e;
         fl   = ($urandom_range(0, 19) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 6);
         d    = $urandom;
         rd   = 5'($urandom_range(0, 7));
         wen  = ($urandom_range(0, 3) != 0);
         q    = 5'($urandom_range(0, 7));
         can_in  = (model_q.size() < 2);
         can_out = (model_q.size() > 0);
         drive(fl, iv, d, rd, wen, ordy, q);
         if (can_out && ordy) void'(model_q.pop_front());
         if (fl) model_q.delete();
         else if (iv && can_in) begin
            e.data = d; e.rd = rd; e.wen = wen;
            model_q.push_back(e);
         end
         exp_rm = 1'b0;
         foreach (model_q[k])
            if (q != 5'd0 && model_q[k].wen && model_q[k].rd == q) exp_rm = 1'b1;
         chk("rand_out_valid", 32'(dn_if.valid), 32'(model_q.size() > 0));
         chk("rand_in_ready",  32'(up_if.ready), 32'(model_q.size() < 2));
         chk("rand_rd_match",  32'(rd_match), 32'(exp_rm));
         if (model_q.size() > 0) begin
            chk("rand_out_data", dn_if.data, model_q[0].data);
            chk("rand_out_rd",   32'(dn_if.rd), 32'(model_q[0].rd));
            chk("rand_out_wen",  32'(dn_if.wen), 32'(model_q[0].wen));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
